uart_rx_pkt_assembler: RTL and testbench
========================================

UART_RX_PKT_ASSEMBLER -- requirements
Module: uart_rx_pkt_assembler

Interface
REQ-001 SHALL have parameter PORTCOUNT, default 5, number of 10-bit symbol lanes per received word (word width W = PORTCOUNT*10).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of packet entries buffered (power of two, >=2).
REQ-003 SHALL have parameter TIMEOUT, default 1023, idle cycles allowed between beats of one packet.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rx_done  input  1  one-cycle strobe from UART receiver: word/comma received.
REQ-007 SHALL have port rx_comma_sel  input  2  kind of received item (1 = COMMA_1_FLIT, 2 = COMMA_2_FLIT, 3 = DATA, 0 = none).
REQ-008 SHALL have port rx_data  input  W  received symbols; comma header in [9:0] (COMMA_1) or [19:0] (COMMA_2).
REQ-009 SHALL have port rx_err  input  1  receiver framing/symbol error, valid with rx_done.
REQ-010 SHALL have port pkt_valid  output  1  FIFO head holds a packet.
REQ-011 SHALL have port pkt_ready  input  1  consumer accepts head when pkt_valid.
REQ-012 SHALL have port pkt_hdr  output  20  packet header, zero-extended for 1-beat packets.
REQ-013 SHALL have port pkt_data  output  2*W  beat0 in [W-1:0], beat1 in [2W-1:W] (zero for 1-beat).
REQ-014 SHALL have port pkt_len  output  1  0 = 1 beat, 1 = 2 beats.
REQ-015 SHALL have port err_pulse  output  1  one-cycle error strobe.
REQ-016 SHALL have port err_code  output  2  1 = ORPHAN, 2 = ABORT, 3 = OVERFLOW; valid with err_pulse, else 0.
REQ-017 SHALL have port drop_cnt  output  8  saturating count of discarded packets/words.

Function
REQ-018 SHALL implement FSM states IDLE, BEAT0, BEAT1; staging regs hdr(20), beat0(W), len(1), tmo counter.
REQ-019 IDLE + rx_done & COMMA_1: hdr <= {10'b0, rx_data[9:0]}, len <= 0, -> BEAT0.
REQ-020 IDLE + rx_done & COMMA_2: hdr <= rx_data[19:0], len <= 1, -> BEAT0.
REQ-021 IDLE + rx_done & DATA: word discarded, err ORPHAN, drop_cnt++; stay IDLE.
REQ-022 BEAT0 + DATA: len=0 -> push {hdr, beat0=rx_data, beat1=0, len}, -> IDLE; len=1 -> beat0 <= rx_data, -> BEAT1.
REQ-023 BEAT1 + DATA: push {hdr, rx_data, beat0, 1}, -> IDLE.
REQ-024 BEAT0/BEAT1 + comma: partial packet discarded, err ABORT, drop_cnt++, new header captured per REQ-019/020, -> BEAT0 same cycle.
REQ-025 Any rx_done with rx_err=1: item and any partial packet discarded, err ABORT (ORPHAN-free), drop_cnt++, -> IDLE.
REQ-026 tmo counter clears on each rx_done, increments in BEAT0/BEAT1; reaching TIMEOUT -> discard, err ABORT, drop_cnt++, -> IDLE.
REQ-027 rx_done with rx_comma_sel=0 SHALL be ignored.
REQ-028 Push latency: packet visible on pkt_valid the cycle after the completing rx_done (1 cycle).
REQ-029 Push when FIFO full and no pop same cycle: packet dropped, err OVERFLOW, drop_cnt++; FIFO contents unchanged.
REQ-030 Push and pop same cycle when full SHALL succeed (count unchanged).
REQ-031 Pop on pkt_valid & pkt_ready; pkt_* outputs stable while pkt_valid & !pkt_ready; pointers wrap modulo FIFO_DEPTH.
REQ-032 drop_cnt SHALL saturate at 255; at most one error/increment per cycle (priority rx_err > OVERFLOW > ABORT > ORPHAN).

Reset
REQ-033 RST SHALL return FSM to IDLE, clear staging, tmo, FIFO pointers/count, drop_cnt.
REQ-034 During/after reset: pkt_valid=0, pkt_hdr=0, pkt_data=0, pkt_len=0, err_pulse=0, err_code=0, drop_cnt=0.
REQ-035 Reset mid-packet SHALL discard partial packet silently (no err_pulse).

Structure
REQ-036 Shared package uart_pkg SHALL hold comma_sel constants (COMMA_1_FLIT/COMMA_2_FLIT/COMMA_DATA), err_code enum, packet entry struct.
REQ-037 FIFO SHALL be sub-module uart_pkt_fifo (sync, parameterised width/depth, full/empty, registered read data).

Verification
REQ-038 COMMA_2 hdr 0x5A5A5, DATA A, DATA B -> one packet hdr=0x5A5A5, data={B,A}, len=1, no err.
REQ-039 COMMA_1 hdr 0x2B7, DATA C -> hdr=0x002B7, data={0,C}, len=0; DATA in IDLE -> err ORPHAN, drop_cnt=1.
REQ-040 COMMA_2, DATA A, then COMMA_1 -> err ABORT, new header taken; following DATA yields 1-beat packet.
REQ-041 pkt_ready=0, send 5 complete packets -> first 4 held, 5th err OVERFLOW, drop_cnt=1; drain -> order preserved.
REQ-042 COMMA_2 then no rx_done for 1023 cycles -> err ABORT, IDLE; DATA with rx_err=1 mid-packet -> ABORT, no push.
REQ-043 Assert RST in BEAT1 -> all outputs 0 next cycle, no err_pulse; 300 orphan words -> drop_cnt holds 255.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet receive path.
//   - comma_sel codes carried on rx_comma_sel
//   - err_code_e: error codes reported on err_code
//   - pkt_meta_t: header/length part of a buffered packet entry
//   - comma_hdr(): extracts a zero-extended header from a comma word
package uart_pkg;

   localparam logic [1:0] COMMA_NONE   = 2'd0;
   localparam logic [1:0] COMMA_1_FLIT = 2'd1;
   localparam logic [1:0] COMMA_2_FLIT = 2'd2;
   localparam logic [1:0] COMMA_DATA   = 2'd3;

   localparam int unsigned HDR_W = 20;

   typedef enum logic [1:0] {
      ErrNone     = 2'd0,
      ErrOrphan   = 2'd1,
      ErrAbort    = 2'd2,
      ErrOverflow = 2'd3
   } err_code_e;

   // Beat data is sized by the top's PORTCOUNT, so only the fixed-size
   // part of an entry lives here; the data beats are concatenated above it.
   typedef struct packed {
      logic             len;
      logic [HDR_W-1:0] hdr;
   } pkt_meta_t;

   localparam int unsigned META_W = $bits(pkt_meta_t);

   // COMMA_1 carries a 10-bit header, COMMA_2 a 20-bit header.
   function automatic logic [HDR_W-1:0] comma_hdr(input logic [1:0]       sel,
                                                  input logic [HDR_W-1:0] lo);
      return (sel == COMMA_1_FLIT) ? {10'b0, lo[9:0]} : lo;
   endfunction

endpackage

// File: rtl/uart_pkt_fifo.sv
// Synchronous FIFO with a registered head entry.
//   clk, rst : clock, synchronous active-high reset
//   push     : write request; taken when not full, or when full with a pop
//   wdata    : entry to write
//   pop      : read request; ignored when empty
//   rdata    : registered head entry (zero when empty)
//   full     : DEPTH entries held
//   empty    : no entries held
module uart_pkt_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = rdata_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers wrap naturally since DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // Head register preloads whatever will sit at rd_ptr after this edge,
      // bypassing the write when that slot is being written now.
      if (count_d == '0) begin
         rdata_d = '0;
      end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
         rdata_d = wdata;
      end else begin
         rdata_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/uart_rx_pkt_assembler.sv
// Assembles UART receiver items (comma header + 1 or 2 data beats) into
// packets and buffers them in a FIFO.
//   CLK, RST         : clock, synchronous active-high reset
//   rx_done          : item strobe from the receiver
//   rx_comma_sel     : item kind (COMMA_1_FLIT / COMMA_2_FLIT / COMMA_DATA / none)
//   rx_data          : item payload, PORTCOUNT*10 bits
//   rx_err           : receiver error, qualifies rx_done
//   pkt_valid/ready  : packet handshake at the FIFO head
//   pkt_hdr/data/len : head packet fields
//   err_pulse/code   : one-cycle error report (ORPHAN/ABORT/OVERFLOW)
//   drop_cnt         : saturating count of discarded packets/words
module uart_rx_pkt_assembler import uart_pkg::*; #(
   parameter int unsigned PORTCOUNT  = 5,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 1023
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        rx_done,
   input  logic [1:0]                  rx_comma_sel,
   input  logic [PORTCOUNT*10-1:0]     rx_data,
   input  logic                        rx_err,
   output logic                        pkt_valid,
   input  logic                        pkt_ready,
   output logic [19:0]                 pkt_hdr,
   output logic [2*PORTCOUNT*10-1:0]   pkt_data,
   output logic                        pkt_len,
   output logic                        err_pulse,
   output logic [1:0]                  err_code,
   output logic [7:0]                  drop_cnt
);

   localparam int unsigned W  = PORTCOUNT * 10;
   localparam int unsigned FW = 2 * W + META_W;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StBeat0, StBeat1} state_e;

   state_e            state_q, state_d;
   logic [HDR_W-1:0]  hdr_q, hdr_d;
   logic [W-1:0]      beat0_q, beat0_d;
   logic              len_q, len_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [7:0]        drop_q, drop_d;
   err_code_e         err_q, err_d;

   logic              item, is_comma, pop;
   logic              push_req;
   logic [W-1:0]      push_beat0, push_beat1;
   pkt_meta_t         push_meta, head_meta;
   logic              fifo_full, fifo_empty;
   logic [FW-1:0]     fifo_rdata;

   // rx_done with kind 0 carries nothing and is ignored entirely.
   assign item     = rx_done && (rx_comma_sel != COMMA_NONE);
   assign is_comma = (rx_comma_sel == COMMA_1_FLIT) || (rx_comma_sel == COMMA_2_FLIT);
   assign pop      = pkt_valid && pkt_ready;

   always_comb begin
      state_d    = state_q;
      hdr_d      = hdr_q;
      beat0_d    = beat0_q;
      len_d      = len_q;
      tmo_d      = tmo_q;
      err_d      = ErrNone;
      push_req   = 1'b0;
      push_beat0 = '0;
      push_beat1 = '0;
      push_meta  = '{len: len_q, hdr: hdr_q};

      if (item) begin
         tmo_d = '0;
         if (rx_err) begin
            state_d = StIdle;
            err_d   = ErrAbort;
         end else if (is_comma) begin
            // A comma always opens a new packet; one in progress is aborted.
            if (state_q != StIdle) err_d = ErrAbort;
            hdr_d   = comma_hdr(rx_comma_sel, rx_data[HDR_W-1:0]);
            len_d   = (rx_comma_sel == COMMA_2_FLIT);
            state_d = StBeat0;
         end else begin
            case (state_q)
               StBeat0: begin
                  if (len_q) begin
                     beat0_d = rx_data;
                     state_d = StBeat1;
                  end else begin
                     push_req   = 1'b1;
                     push_beat0 = rx_data;
                     state_d    = StIdle;
                  end
               end
               StBeat1: begin
                  push_req   = 1'b1;
                  push_beat0 = beat0_q;
                  push_beat1 = rx_data;
                  state_d    = StIdle;
               end
               default: begin
                  err_d   = ErrOrphan;
                  state_d = StIdle;
               end
            endcase
         end
      end else if (state_q != StIdle) begin
         if (tmo_q == TMO_LAST) begin
            state_d = StIdle;
            tmo_d   = '0;
            err_d   = ErrAbort;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end

      // The FIFO itself refuses the write; only the report is made here.
      if (push_req && fifo_full && !pop) err_d = ErrOverflow;

      drop_d = drop_q;
      if ((err_d != ErrNone) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         hdr_q   <= '0;
         beat0_q <= '0;
         len_q   <= 1'b0;
         tmo_q   <= '0;
         drop_q  <= '0;
         err_q   <= ErrNone;
      end else begin
         state_q <= state_d;
         hdr_q   <= hdr_d;
         beat0_q <= beat0_d;
         len_q   <= len_d;
         tmo_q   <= tmo_d;
         drop_q  <= drop_d;
         err_q   <= err_d;
      end
   end

   uart_pkt_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (push_req),
      .wdata ({push_beat1, push_beat0, push_meta}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head_meta = fifo_rdata[META_W-1:0];
   assign pkt_valid = !fifo_empty;
   assign pkt_hdr   = head_meta.hdr;
   assign pkt_len   = head_meta.len;
   assign pkt_data  = fifo_rdata[FW-1:META_W];
   assign err_pulse = (err_q != ErrNone);
   assign err_code  = err_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_uart_rx_pkt_assembler.sv
module tb_uart_rx_pkt_assembler;

   localparam int unsigned PC    = 5;
   localparam int unsigned W     = PC * 10;
   localparam int unsigned DW    = 2 * W;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 1023;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic           rx_done = 1'b0;
   logic [1:0]     rx_comma_sel = 2'd0;
   logic [W-1:0]   rx_data = '0;
   logic           rx_err = 1'b0;
   logic           pkt_valid;
   logic           pkt_ready = 1'b0;
   logic [19:0]    pkt_hdr;
   logic [DW-1:0]  pkt_data;
   logic           pkt_len;
   logic           err_pulse;
   logic [1:0]     err_code;
   logic [7:0]     drop_cnt;

   int checks = 0;
   int errors = 0;

   uart_rx_pkt_assembler #(
      .PORTCOUNT  (PC),
      .FIFO_DEPTH (DEPTH),
      .TIMEOUT    (TMO)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .rx_done      (rx_done),
      .rx_comma_sel (rx_comma_sel),
      .rx_data      (rx_data),
      .rx_err       (rx_err),
      .pkt_valid    (pkt_valid),
      .pkt_ready    (pkt_ready),
      .pkt_hdr      (pkt_hdr),
      .pkt_data     (pkt_data),
      .pkt_len      (pkt_len),
      .err_pulse    (err_pulse),
      .err_code     (err_code),
      .drop_cnt     (drop_cnt)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic [19:0]   hdr;
      logic [DW-1:0] data;
      logic          len;
   } pkt_t;

   pkt_t         exp_q[$];
   bit           m_open;
   int           m_need;
   logic [19:0]  m_hdr;
   logic [W-1:0] m_beats[$];
   int           drop_exp;

   function automatic logic [W-1:0] rnd_word();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[W-1:0];
   endfunction

   function automatic void model_clear();
      exp_q.delete();
      m_beats.delete();
      m_open   = 1'b0;
      m_need   = 0;
      m_hdr    = '0;
      drop_exp = 0;
   endfunction

   function automatic void model_drop();
      if (drop_exp < 255) drop_exp++;
   endfunction

   // Drive one rx_done item for one cycle and update the model; returns the
   // observed and expected error code of that item.
   task automatic send_item(input logic [1:0] sel, input logic [W-1:0] d, input bit e,
                            output logic [1:0] obs, output logic [1:0] exp_e);
      pkt_t p;
      exp_e        = 2'd0;
      rx_done      = 1'b1;
      rx_comma_sel = sel;
      rx_data      = d;
      rx_err       = e;
      if (pkt_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (sel == 2'd0) begin
         exp_e = 2'd0;
      end else if (e) begin
         exp_e  = 2'd2;
         m_open = 1'b0;
         m_beats.delete();
      end else if (sel == 2'd1 || sel == 2'd2) begin
         if (m_open) exp_e = 2'd2;
         m_open = 1'b1;
         m_need = int'(sel);
         m_hdr  = (sel == 2'd1) ? {10'b0, d[9:0]} : d[19:0];
         m_beats.delete();
      end else if (!m_open) begin
         exp_e = 2'd1;
      end else begin
         m_beats.push_back(d);
         if (m_beats.size() == m_need) begin
            p.hdr  = m_hdr;
            p.len  = (m_need == 2);
            p.data = (m_need == 2) ? {m_beats[1], m_beats[0]} : {{W{1'b0}}, m_beats[0]};
            m_open = 1'b0;
            m_beats.delete();
            if (exp_q.size() >= DEPTH) exp_e = 2'd3;
            else exp_q.push_back(p);
         end
      end
      if (exp_e != 2'd0) model_drop();
      @(negedge CLK);
      obs          = err_pulse ? err_code : 2'd0;
      rx_done      = 1'b0;
      rx_comma_sel = 2'd0;
      rx_data      = '0;
      rx_err       = 1'b0;
      pkt_ready    = 1'b0;
   endtask

   task automatic pop_head(output logic v, output logic [19:0] h, output logic [DW-1:0] d,
                           output logic l);
      v = pkt_valid;
      h = pkt_hdr;
      d = pkt_data;
      l = pkt_len;
      pkt_ready = 1'b1;
      @(negedge CLK);
      pkt_ready = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      model_clear();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      checks++;
      if ({pkt_valid, pkt_hdr, pkt_data, pkt_len, err_pulse, err_code, drop_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%0b hdr=%h data=%h len=%0b err=%0b/%0d drop=%0d, want all 0",
                  pkt_valid, pkt_hdr, pkt_data, pkt_len, err_pulse, err_code, drop_cnt);
      end
      RST = 1'b0;
      model_clear();
   endtask

   task automatic test_two_beat();
      logic [1:0] o, x;
      logic [W-1:0] a, b, c;
      do_reset();
      a = rnd_word();
      b = rnd_word();
      c = rnd_word();
      send_item(2'd2, {c[W-1:20], 20'h5A5A5}, 1'b0, o, x);
      send_item(2'd3, a, 1'b0, o, x);
      checks++;
      if (pkt_valid !== 1'b0) begin
         errors++;
         $display("FAIL two_beat_early: pkt_valid=%0b after beat0, want 0", pkt_valid);
      end
      send_item(2'd3, b, 1'b0, o, x);
      checks++;
      if (pkt_valid !== 1'b1 || pkt_hdr !== 20'h5A5A5 || pkt_data !== {b, a} || pkt_len !== 1'b1
          || o !== 2'd0) begin
         errors++;
         $display("FAIL two_beat_pkt: v=%0b hdr=%h data=%h len=%0b err=%0d, want 1 5a5a5 %h 1 0",
                  pkt_valid, pkt_hdr, pkt_data, pkt_len, o, {b, a});
      end
   endtask

   task automatic test_one_beat_orphan();
      logic [1:0] o, x;
      logic [W-1:0] c, r;
      logic v, l;
      logic [19:0] h;
      logic [DW-1:0] d;
      do_reset();
      c = rnd_word();
      r = rnd_word();
      send_item(2'd1, {r[W-1:10], 10'h2B7}, 1'b0, o, x);
      send_item(2'd3, c, 1'b0, o, x);
      pop_head(v, h, d, l);
      checks++;
      if (v !== 1'b1 || h !== 20'h002B7 || d !== {{W{1'b0}}, c} || l !== 1'b0) begin
         errors++;
         $display("FAIL one_beat_pkt: v=%0b hdr=%h data=%h len=%0b, want 1 002b7 %h 0",
                  v, h, d, l, {{W{1'b0}}, c});
      end
      send_item(2'd3, rnd_word(), 1'b0, o, x);
      checks++;
      if (o !== 2'd1 || drop_cnt !== 8'd1) begin
         errors++;
         $display("FAIL orphan: err=%0d drop=%0d, want 1 1", o, drop_cnt);
      end
   endtask

   task automatic test_abort_comma();
      logic [1:0] o, x;
      logic [W-1:0] a, c, r;
      do_reset();
      a = rnd_word();
      c = rnd_word();
      r = rnd_word();
      send_item(2'd2, rnd_word(), 1'b0, o, x);
      send_item(2'd3, a, 1'b0, o, x);
      send_item(2'd1, {r[W-1:10], 10'h155}, 1'b0, o, x);
      checks++;
      if (o !== 2'd2 || drop_cnt !== 8'd1) begin
         errors++;
         $display("FAIL abort_comma: err=%0d drop=%0d, want 2 1", o, drop_cnt);
      end
      send_item(2'd3, c, 1'b0, o, x);
      checks++;
      if (pkt_valid !== 1'b1 || pkt_hdr !== 20'h00155 || pkt_data !== {{W{1'b0}}, c}
          || pkt_len !== 1'b0 || o !== 2'd0) begin
         errors++;
         $display("FAIL abort_new_pkt: v=%0b hdr=%h data=%h len=%0b err=%0d, want 1 00155 %h 0 0",
                  pkt_valid, pkt_hdr, pkt_data, pkt_len, o, {{W{1'b0}}, c});
      end
   endtask

   task automatic test_overflow();
      logic [1:0] o, x;
      logic v, l;
      logic [19:0] h, h0;
      logic [DW-1:0] d, d0;
      pkt_t p;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send_item((i % 2 == 0) ? 2'd1 : 2'd2, rnd_word(), 1'b0, o, x);
         send_item(2'd3, rnd_word(), 1'b0, o, x);
         if (i % 2 == 1) send_item(2'd3, rnd_word(), 1'b0, o, x);
      end
      checks++;
      if (o !== 2'd3 || drop_cnt !== 8'd1 || exp_q.size() != 4) begin
         errors++;
         $display("FAIL overflow: err=%0d drop=%0d, want 3 1", o, drop_cnt);
      end
      h0 = pkt_hdr;
      d0 = pkt_data;
      repeat (3) @(negedge CLK);
      checks++;
      if (pkt_valid !== 1'b1 || pkt_hdr !== h0 || pkt_data !== d0) begin
         errors++;
         $display("FAIL hold_stable: v=%0b hdr=%h, want 1 %h", pkt_valid, pkt_hdr, h0);
      end
      for (int i = 0; i < 4; i++) begin
         p = exp_q.pop_front();
         pop_head(v, h, d, l);
         checks++;
         if (v !== 1'b1 || h !== p.hdr || d !== p.data || l !== p.len) begin
            errors++;
            $display("FAIL drain_order[%0d]: v=%0b hdr=%h len=%0b, want 1 %h %0b",
                     i, v, h, l, p.hdr, p.len);
         end
      end
      checks++;
      if (pkt_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_empty: pkt_valid=%0b, want 0", pkt_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] o, x;
      logic v, l;
      logic [19:0] h;
      logic [DW-1:0] d;
      pkt_t p, f;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send_item(2'd1, rnd_word(), 1'b0, o, x);
         send_item(2'd3, rnd_word(), 1'b0, o, x);
      end
      send_item(2'd2, rnd_word(), 1'b0, o, x);
      send_item(2'd3, rnd_word(), 1'b0, o, x);
      f = exp_q[0];
      h = pkt_hdr;
      d = pkt_data;
      pkt_ready = 1'b1;
      send_item(2'd3, rnd_word(), 1'b0, o, x);
      checks++;
      if (h !== f.hdr || d !== f.data || o !== 2'd0 || drop_cnt !== 8'd0) begin
         errors++;
         $display("FAIL full_push_pop: head=%h err=%0d drop=%0d, want %h 0 0", h, o, drop_cnt,
                  f.hdr);
      end
      for (int i = 0; i < 4; i++) begin
         p = exp_q.pop_front();
         pop_head(v, h, d, l);
         checks++;
         if (v !== 1'b1 || h !== p.hdr || d !== p.data || l !== p.len) begin
            errors++;
            $display("FAIL b2b_drain[%0d]: v=%0b hdr=%h len=%0b, want 1 %h %0b",
                     i, v, h, l, p.hdr, p.len);
         end
      end
   endtask

   task automatic test_timeout_err();
      logic [1:0] o, x, code;
      int seen;
      do_reset();
      send_item(2'd2, rnd_word(), 1'b0, o, x);
      seen = -1;
      code = 2'd0;
      for (int i = 1; i <= 1100; i++) begin
         @(negedge CLK);
         if (err_pulse && seen < 0) begin
            seen = i;
            code = err_code;
         end
      end
      m_open = 1'b0;
      m_beats.delete();
      model_drop();
      checks++;
      if (seen != 1023 || code !== 2'd2 || drop_cnt !== 8'd1) begin
         errors++;
         $display("FAIL timeout: err seen at idle cycle %0d code=%0d drop=%0d, want 1023 2 1",
                  seen, code, drop_cnt);
      end
      send_item(2'd3, rnd_word(), 1'b0, o, x);
      checks++;
      if (o !== 2'd1) begin
         errors++;
         $display("FAIL timeout_idle: err=%0d, want 1", o);
      end
      send_item(2'd2, rnd_word(), 1'b0, o, x);
      send_item(2'd3, rnd_word(), 1'b0, o, x);
      send_item(2'd3, rnd_word(), 1'b1, o, x);
      checks++;
      if (o !== 2'd2 || x !== 2'd2 || pkt_valid !== 1'b0 || drop_cnt !== 8'(drop_exp)) begin
         errors++;
         $display("FAIL rx_err_abort: err=%0d valid=%0b drop=%0d, want 2 0 %0d",
                  o, pkt_valid, drop_cnt, drop_exp);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] o, x;
      do_reset();
      send_item(2'd3, rnd_word(), 1'b0, o, x);
      send_item(2'd1, rnd_word(), 1'b0, o, x);
      send_item(2'd3, rnd_word(), 1'b0, o, x);
      send_item(2'd2, rnd_word(), 1'b0, o, x);
      send_item(2'd3, rnd_word(), 1'b0, o, x);
      RST = 1'b1;
      @(negedge CLK);
      checks++;
      if ({pkt_valid, pkt_hdr, pkt_data, pkt_len, err_pulse, err_code, drop_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_mid: valid=%0b hdr=%h len=%0b err=%0b/%0d drop=%0d, want all 0",
                  pkt_valid, pkt_hdr, pkt_len, err_pulse, err_code, drop_cnt);
      end
      RST = 1'b0;
      model_clear();
      @(negedge CLK);
      checks++;
      if (err_pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_silent: err_pulse=%0b, want 0", err_pulse);
      end
      send_item(2'd3, rnd_word(), 1'b0, o, x);
      checks++;
      if (o !== 2'd1) begin
         errors++;
         $display("FAIL reset_mid_idle: err=%0d, want 1", o);
      end
   endtask

   task automatic test_saturate();
      logic [1:0] o, x;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         send_item(2'd3, rnd_word(), 1'b0, o, x);
         checks++;
         if (o !== 2'd1) begin
            errors++;
            $display("FAIL sat_orphan[%0d]: err=%0d, want 1", i, o);
         end
      end
      checks++;
      if (drop_cnt !== 8'd255) begin
         errors++;
         $display("FAIL drop_saturate: drop_cnt=%0d, want 255", drop_cnt);
      end
   endtask

   task automatic test_random();
      logic [1:0] o, x, sel;
      logic v, l;
      logic [19:0] h;
      logic [DW-1:0] d;
      int k;
      bit e;
      pkt_t p;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         k = $urandom_range(0, 19);
         e = 1'b0;
         if (k == 0) sel = 2'd0;
         else if (k == 1) begin sel = 2'd3; e = 1'b1; end
         else if (k < 6) sel = 2'd1;
         else if (k < 10) sel = 2'd2;
         else sel = 2'd3;
         pkt_ready = ($urandom_range(0, 2) == 0);
         checks++;
         if (pkt_valid !== (exp_q.size() > 0)) begin
            errors++;
            $display("FAIL rand_valid[%0d]: pkt_valid=%0b, want %0b", i, pkt_valid,
                     exp_q.size() > 0);
         end
         if (pkt_ready && exp_q.size() > 0) begin
            checks++;
            if (pkt_hdr !== exp_q[0].hdr || pkt_data !== exp_q[0].data
                || pkt_len !== exp_q[0].len) begin
               errors++;
               $display("FAIL rand_head[%0d]: hdr=%h len=%0b, want %h %0b", i, pkt_hdr,
                        pkt_len, exp_q[0].hdr, exp_q[0].len);
            end
         end
         send_item(sel, rnd_word(), e, o, x);
         checks++;
         if (o !== x) begin
            errors++;
            $display("FAIL rand_err[%0d]: err=%0d, want %0d", i, o, x);
         end
         if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
      end
      while (exp_q.size() > 0) begin
         p = exp_q.pop_front();
         pop_head(v, h, d, l);
         checks++;
         if (v !== 1'b1 || h !== p.hdr || d !== p.data || l !== p.len) begin
            errors++;
            $display("FAIL rand_drain: v=%0b hdr=%h len=%0b, want 1 %h %0b", v, h, l,
                     p.hdr, p.len);
         end
      end
      checks++;
      if (pkt_valid !== 1'b0 || drop_cnt !== 8'(drop_exp)) begin
         errors++;
         $display("FAIL rand_final: valid=%0b drop=%0d, want 0 %0d", pkt_valid, drop_cnt,
                  drop_exp);
      end
   endtask

   initial begin
      model_clear();
      @(negedge CLK);
      test_reset();
      test_two_beat();
      test_one_beat_orphan();
      test_abort_comma();
      test_overflow();
      test_back_to_back();
      test_timeout_err();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
